// File: rtl/multi_cycle_ctrl_if.sv
// Handshake/control bundle between the multi-cycle controller and the CPU
// datapath. The master side is the controller: it consumes the opcode, the
// ALU zero flag and (when MC_MEM_WAIT_EN is defined) the memory-ready
// handshake, and produces every datapath control plus status.
interface multi_cycle_ctrl_if;

  // Inputs to the controller
  logic [5:0]  opcode;
  logic        zero;
`ifdef MC_MEM_WAIT_EN
  logic        mem_ready;
`endif

  // Outputs of the controller
  logic [2:0]  state;
  logic        IRWre;
  logic        PCWre;
  logic        InsMemRW;
  logic        ExtSel;
  logic        RegOut;
  logic        RegWre;
  logic        PCSrc;
  logic        ALUSrcB;
  logic        DataMemRW;
  logic        ALUM2Reg;
  logic [2:0]  ALUOp;
  logic        halted;
  logic [15:0] instr_cnt;

`ifdef MC_MEM_WAIT_EN
  modport master (
    input  opcode, zero, mem_ready,
    output state, IRWre, PCWre, InsMemRW, ExtSel, RegOut, RegWre, PCSrc,
           ALUSrcB, DataMemRW, ALUM2Reg, ALUOp, halted, instr_cnt
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  state, IRWre, PCWre, InsMemRW, ExtSel, RegOut, RegWre, PCSrc,
           ALUSrcB, DataMemRW, ALUM2Reg, ALUOp, halted, instr_cnt
  );
`else
  modport master (
    input  opcode, zero,
    output state, IRWre, PCWre, InsMemRW, ExtSel, RegOut, RegWre, PCSrc,
           ALUSrcB, DataMemRW, ALUM2Reg, ALUOp, halted, instr_cnt
  );

  modport slave (
    output opcode, zero,
    input  state, IRWre, PCWre, InsMemRW, ExtSel, RegOut, RegWre, PCSrc,
           ALUSrcB, DataMemRW, ALUM2Reg, ALUOp, halted, instr_cnt
  );
`endif

endinterface

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control unit. Sequences each instruction through
// IF/ID/EXE/MEM/WB, drives the datapath controls combinationally from the
// current state, the opcode and the ALU zero flag, parks in HALT on the halt
// opcode and counts retired instructions (one per PCWre pulse).
//
// Optional feature macro: MC_MEM_WAIT_EN
//   defined   - IF and MEM stretch until bus.mem_ready is high
//   undefined - IF and MEM always last exactly one cycle
module multi_cycle_ctrl (
  input  logic              CLK,
  input  logic              Reset,
  multi_cycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    ST_IF   = 3'b000,
    ST_ID   = 3'b001,
    ST_EXE  = 3'b010,
    ST_MEM  = 3'b011,
    ST_WB   = 3'b100,
    ST_HALT = 3'b101
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b000001;
  localparam logic [5:0] OP_SUB  = 6'b000010;
  localparam logic [5:0] OP_ORI  = 6'b000011;
  localparam logic [5:0] OP_AND  = 6'b000100;
  localparam logic [5:0] OP_OR   = 6'b000101;
  localparam logic [5:0] OP_MOVE = 6'b000110;
  localparam logic [5:0] OP_SW   = 6'b000111;
  localparam logic [5:0] OP_LW   = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b001001;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e      state_q;
  state_e      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;

  // Opcode classification
  logic        op_known;
  logic        op_halt;
  logic        op_beq;
  logic        op_sw;
  logic        op_lw;
  logic        op_imm;
  logic [2:0]  op_aluop;

  // Memory handshake, tied high when the wait feature is compiled out
  logic        mem_ok;

  // Control word before reset gating
  logic        pcwre_raw;
  logic        irwre_raw;
  logic        regwre_raw;
  logic        pcsrc_raw;
  logic        dmw_raw;
  logic        decode_en;

`ifdef MC_MEM_WAIT_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  // Decode the opcode into instruction class and ALU function
  always_comb begin
    op_known = 1'b0;
    op_halt  = 1'b0;
    op_beq   = 1'b0;
    op_sw    = 1'b0;
    op_lw    = 1'b0;
    op_imm   = 1'b0;
    op_aluop = 3'b000;
    unique case (bus.opcode)
      OP_ADD:  begin op_known = 1'b1; op_aluop = 3'b000; end
      OP_ADDI: begin op_known = 1'b1; op_aluop = 3'b000; op_imm = 1'b1; end
      OP_SUB:  begin op_known = 1'b1; op_aluop = 3'b001; end
      OP_ORI:  begin op_known = 1'b1; op_aluop = 3'b011; op_imm = 1'b1; end
      OP_AND:  begin op_known = 1'b1; op_aluop = 3'b100; end
      OP_OR:   begin op_known = 1'b1; op_aluop = 3'b011; end
      OP_MOVE: begin op_known = 1'b1; op_aluop = 3'b000; end
      OP_SW:   begin op_known = 1'b1; op_aluop = 3'b000; op_imm = 1'b1; op_sw = 1'b1; end
      OP_LW:   begin op_known = 1'b1; op_aluop = 3'b000; op_imm = 1'b1; op_lw = 1'b1; end
      OP_BEQ:  begin op_known = 1'b1; op_aluop = 3'b001; op_beq = 1'b1; end
      OP_HALT: begin op_halt  = 1'b1; end
      default: begin end
    endcase
  end

  // Next-state sequencing; an unknown opcode falls back to IF as a NOP
  always_comb begin
    state_d = ST_IF;
    case (state_q)
      ST_IF:   state_d = mem_ok ? ST_ID : ST_IF;
      ST_ID: begin
        if (op_halt)       state_d = ST_HALT;
        else if (op_known) state_d = ST_EXE;
        else               state_d = ST_IF;
      end
      ST_EXE: begin
        if (op_beq)              state_d = ST_IF;
        else if (op_lw || op_sw) state_d = ST_MEM;
        else                     state_d = ST_WB;
      end
      ST_MEM: begin
        if (!mem_ok)    state_d = ST_MEM;
        else if (op_sw) state_d = ST_IF;
        else            state_d = ST_WB;
      end
      ST_WB:   state_d = ST_IF;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IF;
    endcase
  end

  // Strobes and the single PC-write pulse that marks an instruction's last cycle
  always_comb begin
    irwre_raw  = 1'b0;
    regwre_raw = 1'b0;
    pcsrc_raw  = 1'b0;
    dmw_raw    = 1'b0;
    pcwre_raw  = 1'b0;
    decode_en  = 1'b0;
    case (state_q)
      ST_IF: begin
        irwre_raw = 1'b1;
      end
      ST_ID: begin
        decode_en = 1'b1;
        pcwre_raw = !op_known && !op_halt;
      end
      ST_EXE: begin
        decode_en = 1'b1;
        pcsrc_raw = op_beq && bus.zero;
        pcwre_raw = op_beq;
      end
      ST_MEM: begin
        decode_en = 1'b1;
        dmw_raw   = op_sw;
        pcwre_raw = op_sw && mem_ok;
      end
      ST_WB: begin
        decode_en  = 1'b1;
        regwre_raw = 1'b1;
        pcwre_raw  = 1'b1;
      end
      default: begin end
    endcase
  end

  // Drive the bus; Reset forces every output except state to zero so an
  // aborted instruction can never write the PC, registers or memory
  always_comb begin
    bus.state     = state_q;
    bus.IRWre     = 1'b0;
    bus.InsMemRW  = 1'b0;
    bus.PCWre     = 1'b0;
    bus.RegWre    = 1'b0;
    bus.PCSrc     = 1'b0;
    bus.DataMemRW = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.RegOut    = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ALUM2Reg  = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.halted    = 1'b0;
    bus.instr_cnt = 16'h0000;
    if (!Reset) begin
      bus.IRWre     = irwre_raw;
      bus.InsMemRW  = irwre_raw;
      bus.PCWre     = pcwre_raw;
      bus.RegWre    = regwre_raw;
      bus.PCSrc     = pcsrc_raw;
      bus.DataMemRW = dmw_raw;
      bus.halted    = (state_q == ST_HALT);
      bus.instr_cnt = cnt_q;
      if (decode_en) begin
        bus.ALUOp    = op_aluop;
        bus.ALUSrcB  = op_imm;
        bus.ExtSel   = op_imm || op_beq;
        bus.RegOut   = !op_imm;
        bus.ALUM2Reg = op_lw;
      end
    end
  end

  // Retired-instruction counter; wraps naturally at 16 bits
  always_comb begin
    cnt_d = cnt_q + {15'd0, pcwre_raw};
  end

  // State and counter registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= ST_IF;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Self-checking bench for multi_cycle_ctrl. Each instruction is expanded into
// its expected list of states from the opcode class; the expected controls for
// every cycle follow from the state, the opcode table and the rule that PCWre
// marks the last cycle of a non-halt instruction.
module tb_multi_cycle_ctrl;

  localparam logic [2:0] S_IF   = 3'b000;
  localparam logic [2:0] S_ID   = 3'b001;
  localparam logic [2:0] S_EXE  = 3'b010;
  localparam logic [2:0] S_MEM  = 3'b011;
  localparam logic [2:0] S_WB   = 3'b100;
  localparam logic [2:0] S_HALT = 3'b101;

  localparam logic [5:0] ADD  = 6'd0;
  localparam logic [5:0] SW   = 6'd7;
  localparam logic [5:0] LW   = 6'd8;
  localparam logic [5:0] BEQ  = 6'd9;
  localparam logic [5:0] HALT = 6'h3f;

  logic CLK;
  logic Reset;
  int   n_checks;
  int   n_fail;
  logic [15:0] cnt_model;

  multi_cycle_ctrl_if bus_if ();

  multi_cycle_ctrl dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Observed control word: {state, IRWre, InsMemRW, PCWre, ExtSel, RegOut,
  // RegWre, PCSrc, ALUSrcB, DataMemRW, ALUM2Reg, ALUOp, halted}
  function automatic logic [16:0] observed();
    return {bus_if.state, bus_if.IRWre, bus_if.InsMemRW, bus_if.PCWre,
            bus_if.ExtSel, bus_if.RegOut, bus_if.RegWre, bus_if.PCSrc,
            bus_if.ALUSrcB, bus_if.DataMemRW, bus_if.ALUM2Reg, bus_if.ALUOp,
            bus_if.halted};
  endfunction

  // Opcode table: returns {ALUOp, ALUSrcB, ExtSel, RegOut, ALUM2Reg}
  function automatic logic [6:0] op_fields(input logic [5:0] op);
    logic [2:0] aop;
    logic       imm;
    aop = 3'b000;
    imm = (op == 6'd1) || (op == 6'd3) || (op == SW) || (op == LW);
    if (op == 6'd2 || op == BEQ) aop = 3'b001;
    if (op == 6'd3 || op == 6'd5) aop = 3'b011;
    if (op == 6'd4) aop = 3'b100;
    return {aop, imm, imm || (op == BEQ), !imm, op == LW};
  endfunction

  task automatic check(input logic [16:0] exp, input logic [16:0] mask,
                       input logic [15:0] exp_cnt, input string tag);
    logic [16:0] got;
    got = observed() & mask;
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s ctrl: observed=%b expected=%b", tag, got, exp);
    end
    n_checks++;
    assert (bus_if.instr_cnt === exp_cnt) else begin
      n_fail++;
      $error("FAIL %s instr_cnt: observed=%0d expected=%0d", tag, bus_if.instr_cnt, exp_cnt);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_random();
    bus_if.opcode = 6'($urandom);
    bus_if.zero   = 1'($urandom);
`ifdef MC_MEM_WAIT_EN
    bus_if.mem_ready = 1'($urandom);
`endif
  endtask

  // Hold Reset for n cycles; outputs other than state must read zero and the
  // state must be IF once a reset edge has been seen
  task automatic do_reset(input int n);
    Reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      drive_random();
      #1;
      if (i == 0) check(17'd0, 17'h03fff, 16'd0, "reset");
      else        check({S_IF, 14'd0}, 17'h1ffff, 16'd0, "reset");
      tick();
    end
    Reset = 1'b0;
    cnt_model = 16'd0;
    $display("reset for %0d cycles", n);
  endtask

  // Run one instruction; abort_at >= 0 raises Reset in that cycle and returns
  task automatic run_instr(input logic [5:0] op, input logic z,
                           input int w_if, input int w_mem, input int abort_at);
    logic [2:0]  seq [$];
    logic        rdy [$];
    logic [2:0]  s;
    logic        last;
    logic        is_halt;
    logic        known;
    logic        pcw;
    logic [6:0]  f;
    logic [16:0] exp;
    is_halt = (op == HALT);
    known   = (op <= BEQ);
    for (int i = 0; i < w_if; i++) begin seq.push_back(S_IF); rdy.push_back(1'b0); end
    seq.push_back(S_IF); rdy.push_back(1'b1);
    seq.push_back(S_ID); rdy.push_back(1'($urandom));
    if (is_halt) begin
      seq.push_back(S_HALT); rdy.push_back(1'($urandom));
    end else if (known) begin
      seq.push_back(S_EXE); rdy.push_back(1'($urandom));
      if (op == SW || op == LW) begin
        for (int i = 0; i < w_mem; i++) begin seq.push_back(S_MEM); rdy.push_back(1'b0); end
        seq.push_back(S_MEM); rdy.push_back(1'b1);
      end
      if (op != BEQ && op != SW) begin
        seq.push_back(S_WB); rdy.push_back(1'($urandom));
      end
    end
    for (int k = 0; k < seq.size(); k++) begin
      s    = seq[k];
      last = (k == seq.size() - 1);
      Reset = (k == abort_at);
      bus_if.opcode = (s == S_IF) ? 6'($urandom) : op;
      bus_if.zero   = (s == S_EXE) ? z : 1'($urandom);
`ifdef MC_MEM_WAIT_EN
      bus_if.mem_ready = rdy[k];
`endif
      #1;
      if (Reset) begin
        check({s, 14'd0}, 17'h1ffff, 16'd0, "abort");
        tick();
        return;
      end
      pcw = last && !is_halt;
      f   = (s == S_IF || s == S_HALT) ? 7'd0 : op_fields(op);
      exp = {s, s == S_IF, s == S_IF, pcw, f[2], f[1], s == S_WB,
             (s == S_EXE) && (op == BEQ) && z, f[3],
             (s == S_MEM) && (op == SW), f[0], f[6:4], s == S_HALT};
      check(exp, 17'h1ffff, cnt_model, "instr");
      if (pcw) cnt_model = cnt_model + 16'd1;
      tick();
    end
    $display("instr op=%b zero=%0d cycles=%0d instr_cnt=%0d", op, z, seq.size(), cnt_model);
  endtask

  int w_if;
  int w_mem;
  int r;
  logic [5:0] rop;

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    cnt_model = 16'd0;
    Reset     = 1'b1;
    drive_random();
    tick();
    do_reset(2);

    // Directed sequence following the test plan
    run_instr(ADD, 1'b0, 0, 0, -1);
    run_instr(LW, 1'b0, 0, 0, -1);
    run_instr(BEQ, 1'b1, 0, 0, -1);
    run_instr(BEQ, 1'b0, 0, 0, -1);
    run_instr(SW, 1'b0, 0, 0, -1);
    run_instr(HALT, 1'b0, 0, 0, -1);
    for (int i = 0; i < 10; i++) begin
      drive_random();
      #1;
      check({S_HALT, 13'd0, 1'b1}, 17'h1ffff, cnt_model, "halt_hold");
      tick();
    end
    $display("halt held 10 cycles instr_cnt=%0d", cnt_model);
    do_reset(1);
    run_instr(6'b010101, 1'b0, 0, 0, -1);
`ifdef MC_MEM_WAIT_EN
    run_instr(SW, 1'b0, 2, 3, -1);
    run_instr(LW, 1'b1, 1, 2, -1);
`endif
    run_instr(ADD, 1'b0, 0, 0, 2);
    do_reset(2);

    // Randomized instruction stream, including unknown opcodes
    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 11);
      if (r <= 9) rop = 6'(r);
      else        rop = 6'($urandom_range(10, 62));
      w_if  = 0;
      w_mem = 0;
`ifdef MC_MEM_WAIT_EN
      w_if  = $urandom_range(0, 2);
      w_mem = $urandom_range(0, 2);
`endif
      run_instr(rop, 1'($urandom), w_if, w_mem, -1);
    end
    run_instr(HALT, 1'b0, 0, 0, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
